// File: rtl/mux_logic_unit.sv
// Purpose : truth-table logic unit; every gate is a 4:1 mux selecting tt[{x,y}].
//           Bitwise mode applies tt to each (a[i],b[i]) pair; reduce mode folds a serially.
// Latency : bitwise 1 cycle; reduce WIDTH cycles (1 cycle when WIDTH==1).
// Backpressure: result held in HOLD until out_ready; a new request may be taken on the
//           same edge the result retires, so bitwise streams run at one result per cycle.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - request handshake; a, b, tt, reduce sampled on acceptance
//   a, b [WIDTH]        - operands (b unused in reduce mode)
//   tt [4]              - truth table, f(x,y) = tt[{x,y}]
//   reduce              - 0 = bitwise, 1 = serial fold of a
//   out_valid/out_ready - result handshake; y stable while stalled
//   y [WIDTH]           - result
//   busy                - high while the serial fold is running
module mux_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       tt,
  input  logic             reduce,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int IW = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] a_cap_q, a_cap_d;
  logic [3:0]       tt_cap_q, tt_cap_d;
  logic             acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [WIDTH-1:0] a_shift;
  logic             a_bit;
  logic             acc_next;
  logic             accept;

  // The single gate primitive: 4:1 mux with the truth table on the data inputs.
  function automatic logic mux4(input logic [3:0] t, input logic x, input logic s);
    return t[{x, s}];
  endfunction

  assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == RUN);
  assign y         = y_q;
  assign accept    = in_valid && in_ready;

  // Shift rather than index so the wider counter never selects outside a_cap.
  assign a_shift  = a_cap_q >> idx_q;
  assign a_bit    = a_shift[0];
  assign acc_next = mux4(tt_cap_q, acc_q, a_bit);

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    a_cap_d  = a_cap_q;
    tt_cap_d = tt_cap_q;
    acc_d    = acc_q;
    idx_d    = idx_q;

    case (state_q)
      IDLE: ;
      RUN: begin
        acc_d = acc_next;
        if (idx_q == IDX_LAST) begin
          // Last bit folded: publish the single-bit result; counter parks here.
          y_d     = '0;
          y_d[0]  = acc_next;
          state_d = HOLD;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end
      HOLD: begin
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance overrides the above; from HOLD this also retires the old result.
    if (accept) begin
      a_cap_d  = a;
      tt_cap_d = tt;
      if (!reduce) begin
        for (int i = 0; i < WIDTH; i++) begin
          y_d[i] = mux4(tt, a[i], b[i]);
        end
        state_d = HOLD;
      end else if (WIDTH == 1) begin
        // Nothing to fold: the result is a[0] itself.
        y_d     = '0;
        y_d[0]  = a[0];
        acc_d   = a[0];
        state_d = HOLD;
      end else begin
        acc_d   = a[0];
        idx_d   = IDX_ONE;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      y_q      <= '0;
      a_cap_q  <= '0;
      tt_cap_q <= '0;
      acc_q    <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      a_cap_q  <= a_cap_d;
      tt_cap_q <= tt_cap_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: doc/mux_logic_unit.md
MUX_LOGIC_UNIT -- requirements
Module: mux_logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request presented.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B; ignored in reduce mode.
REQ-008 SHALL have port tt  input  4  truth table; function of (x,y) = tt[{x,y}].
REQ-009 SHALL have port reduce  input  1  0 = bitwise mode, 1 = serial fold of a.
REQ-010 SHALL have port out_valid  output  1  result y is valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port y  output  WIDTH  result.
REQ-013 SHALL have port busy  output  1  high in RUN state.

Function
REQ-014 SHALL implement every gate evaluation as a 4:1 mux with tt as data inputs and {x,y} as select; NAND=4'b0111, NOR=4'b0001, AND=4'b1000, OR=4'b1110, XOR=4'b0110, XNOR=4'b1001.
REQ-015 SHALL use FSM states IDLE, RUN, HOLD; reset state IDLE.
REQ-016 SHALL accept a request when in_valid && in_ready at a rising edge; tt, reduce and a SHALL be captured at acceptance and held internally.
REQ-017 SHALL drive in_ready = (state==IDLE) || (state==HOLD && out_ready).
REQ-018 Bitwise accept: y[i] = tt[{a[i],b[i]}] for all i, registered; next state HOLD; out_valid in the cycle after acceptance.
REQ-019 Reduce accept with WIDTH>=2: acc <= a[0], index <= 1, next state RUN.
REQ-020 RUN, each cycle: acc <= tt[{acc, a_cap[index]}], index increments; after processing index WIDTH-1, y <= {zeros, new acc}, next state HOLD.
REQ-021 Reduce result SHALL have out_valid in cycle c+WIDTH for acceptance in cycle c; upper WIDTH-1 bits of y SHALL be 0.
REQ-022 Reduce with WIDTH==1: y <= a[0], go directly IDLE->HOLD, out_valid in the cycle after acceptance.
REQ-023 out_valid SHALL equal (state==HOLD); y SHALL be stable while out_valid && !out_ready.
REQ-024 HOLD && out_ready && !in_valid: next state IDLE, out_valid drops next cycle.
REQ-025 HOLD && out_ready && in_valid: result retires and new request is accepted in the same edge (zero bubble); bitwise back-to-back gives one result per cycle.
REQ-026 in_valid in RUN SHALL be ignored (in_ready low); changes to a, b, tt, reduce after acceptance SHALL NOT affect the pending result.
REQ-027 index counter SHALL be ceil(log2(WIDTH))+1 bits wide and never wrap past WIDTH-1.

Reset
REQ-028 rst high SHALL immediately force state IDLE, y=0, out_valid=0, busy=0, acc=0, index=0, in_ready=1 (after reset release).
REQ-029 rst asserted mid-RUN or in HOLD SHALL discard the operation; no result is produced after release.

Verification (WIDTH=8)
REQ-030 Bitwise tt=4'b0111, a=8'hF0, b=8'hCC -> y=8'h3F, out_valid one cycle after accept; tt=4'b0001 same operands -> y=8'h03.
REQ-031 Reduce tt=4'b0110, a=8'hB5, accept cycle c -> busy cycles c+1..c+7, out_valid at c+8, y=8'h01; tt=4'b1000, a=8'hFE -> y=8'h00.
REQ-032 out_ready=0 for 5 cycles in HOLD -> y, out_valid stable, in_ready=0; then out_ready=1 -> retire.
REQ-033 Back-to-back bitwise stream of 4 requests with out_ready=1 -> 4 results on 4 consecutive cycles, in order.
REQ-034 rst pulsed at cycle c+4 of a reduce -> outputs 0 immediately, in_ready=1 after release, no stray out_valid.
REQ-035 Change a and tt during RUN -> result matches captured values only.
